// File: rtl/freq_gen.sv
// -----------------------------------------------------------------------------
// freq_gen -- programmable 50 % duty square-wave generator.
//
// A requested frequency (Hz) is turned into a half-period in clk cycles by an
// iterative restoring divider (CLK_FREQ / (2*f)), then used to toggle a
// registered square wave. Changes while running are phase-continuous: a new
// half-period is adopted only at a toggle point.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   freq_set     requested frequency in Hz, 0 = stop
//   set_valid    request strobe for freq_set
//   set_ready    high when a new request can be accepted
//   wave_out     generated square wave (flop output)
//   running      high while wave_out is toggling
//   half_period  half-period in effect, clk cycles (0 when stopped)
//   done         one-cycle pulse when a new setting takes effect
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request (set_ready when no update pending)
// DIV   | restoring divide, one quotient bit per cycle, MSB first
// LOAD  | apply result immediately (stopped) or park it as pending
// -----------------------------------------------------------------------------
module freq_gen #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int FREQ_W   = 19,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [FREQ_W-1:0] freq_set,
    input  logic              set_valid,
    output logic              set_ready,
    output logic              wave_out,
    output logic              running,
    output logic [CNT_W-1:0]  half_period,
    output logic              done
);

    // Remainder is always below the divisor (2*f), so FREQ_W+1 bits suffice;
    // the shifted partial remainder needs one more.
    localparam int REM_W = FREQ_W + 1;
    localparam int SH_W  = FREQ_W + 2;
    localparam int BIT_W = $clog2(CNT_W);
    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_FREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   quo_q, quo_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   half_period_q, half_period_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic               wave_q, wave_d;
    logic               running_q, running_d;
    logic               done_q, done_d;

    logic [SH_W-1:0]    rem_shift;
    logic [SH_W-1:0]    divisor;
    logic [CNT_W-1:0]   result;
    logic               toggle;
    logic               accept;

    assign set_ready   = (state_q == IDLE) && !pend_valid_q;
    assign accept      = set_valid && set_ready;
    assign wave_out    = wave_q;
    assign running     = running_q;
    assign half_period = half_period_q;
    assign done        = done_q;

    always_comb begin
        state_d       = state_q;
        freq_d        = freq_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        bit_d         = bit_q;
        cnt_d         = cnt_q;
        half_period_d = half_period_q;
        pend_d        = pend_q;
        pend_valid_d  = pend_valid_q;
        wave_d        = wave_q;
        running_d     = running_q;
        done_d        = 1'b0;

        divisor   = {1'b0, freq_q, 1'b0};
        rem_shift = {rem_q, DIVIDEND[bit_q]};

        // f==0 stops; a zero quotient means f > CLK_FREQ/2, clamp to fastest.
        if (freq_q == '0) begin
            result = '0;
        end else if (quo_q == '0) begin
            result = CNT_W'(1);
        end else begin
            result = quo_q;
        end

        toggle = running_q && (cnt_q == half_period_q - CNT_W'(1));

        // Wave generation; a pending update is taken only at a level boundary.
        if (running_q) begin
            if (toggle) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
                if (pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    done_d       = 1'b1;
                    if (pend_q != '0) begin
                        half_period_d = pend_q;
                    end else begin
                        // Stop: a low level simply stays low, no runt pulse.
                        wave_d        = 1'b0;
                        running_d     = 1'b0;
                        half_period_d = '0;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    freq_d  = freq_set;
                    rem_d   = '0;
                    quo_d   = '0;
                    bit_d   = BIT_W'(CNT_W - 1);
                    state_d = DIV;
                end
            end
            DIV: begin
                if (rem_shift >= divisor) begin
                    rem_d = REM_W'(rem_shift - divisor);
                    quo_d = {quo_q[CNT_W-2:0], 1'b1};
                end else begin
                    rem_d = REM_W'(rem_shift);
                    quo_d = {quo_q[CNT_W-2:0], 1'b0};
                end
                if (bit_q == '0) begin
                    state_d = LOAD;
                end else begin
                    bit_d = bit_q - BIT_W'(1);
                end
            end
            LOAD: begin
                state_d = IDLE;
                if (!running_q) begin
                    done_d = 1'b1;
                    if (result != '0) begin
                        half_period_d = result;
                        cnt_d         = '0;
                        wave_d        = 1'b1;
                        running_d     = 1'b1;
                    end
                end else begin
                    // pend_valid_q is necessarily clear here, so the toggle
                    // logic above cannot have touched the pending register.
                    pend_d       = result;
                    pend_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            freq_q        <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            bit_q         <= '0;
            cnt_q         <= '0;
            half_period_q <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            wave_q        <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            freq_q        <= freq_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            bit_q         <= bit_d;
            cnt_q         <= cnt_d;
            half_period_q <= half_period_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            wave_q        <= wave_d;
            running_q     <= running_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_freq_gen.sv
// -----------------------------------------------------------------------------
// tb_freq_gen -- self-checking bench for freq_gen.
//
// A behavioural reference model (plain integer division, level lengths and a
// busy countdown) is stepped on every clk edge and compared with all DUT
// outputs on the falling edge. Directed sequences cover the documented
// frequency points; a random section mixes stops, clamps and ordinary rates.
// FREQ_W is widened so that requests above CLK_FREQ/2 can be expressed.
// -----------------------------------------------------------------------------
module tb_freq_gen;

    localparam int CLK_FREQ = 25_000_000;
    localparam int FREQ_W   = 25;
    localparam int CNT_W    = 32;

    logic              clk;
    logic              rstn;
    logic [FREQ_W-1:0] freq_set;
    logic              set_valid;
    logic              set_ready;
    logic              wave_out;
    logic              running;
    logic [CNT_W-1:0]  half_period;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    freq_gen #(
        .CLK_FREQ (CLK_FREQ),
        .FREQ_W   (FREQ_W),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .freq_set    (freq_set),
        .set_valid   (set_valid),
        .set_ready   (set_ready),
        .wave_out    (wave_out),
        .running     (running),
        .half_period (half_period),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CNT_W-1:0]  hp;    // half-period in effect
        logic [CNT_W-1:0]  left;  // cycles left in current level
        logic [CNT_W-1:0]  pend;
        logic              pv;
        logic              wave;
        logic              done;
        logic [7:0]        busy;  // cycles until the computed value is applied
        logic [FREQ_W-1:0] req;
    } mstate_t;

    mstate_t m;

    function automatic logic [CNT_W-1:0] ref_hp(input logic [FREQ_W-1:0] f);
        longint q;
        if (f == '0) return '0;
        q = longint'(CLK_FREQ) / (2 * longint'(f));
        if (q == 0) return CNT_W'(1);
        return CNT_W'(q);
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic v, input logic [FREQ_W-1:0] f);
        mstate_t          n;
        logic             rdy;
        logic [CNT_W-1:0] res;
        n      = s;
        n.done = 1'b0;
        rdy    = (s.busy == 8'd0) && !s.pv;
        if (s.hp != '0) begin
            if (s.left == CNT_W'(1)) begin
                n.wave = ~s.wave;
                n.left = s.hp;
                if (s.pv) begin
                    n.pv   = 1'b0;
                    n.done = 1'b1;
                    if (s.pend != '0) begin
                        n.hp   = s.pend;
                        n.left = s.pend;
                    end else begin
                        n.hp   = '0;
                        n.left = '0;
                        n.wave = 1'b0;
                    end
                end
            end else begin
                n.left = s.left - CNT_W'(1);
            end
        end
        if (s.busy == 8'd1) begin
            res = ref_hp(s.req);
            if (s.hp == '0) begin
                n.done = 1'b1;
                if (res != '0) begin
                    n.hp   = res;
                    n.left = res;
                    n.wave = 1'b1;
                end
            end else begin
                n.pend = res;
                n.pv   = 1'b1;
            end
        end
        if (s.busy != 8'd0) n.busy = s.busy - 8'd1;
        if (rdy && v) begin
            n.busy = 8'(CNT_W + 1);
            n.req  = f;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '0;
        else       m <= step(m, set_valid, freq_set);
    end

    always @(negedge clk) begin
        if (rstn && mon_en) begin
            chk("mon_wave",  wave_out,    m.wave);
            chk("mon_hp",    half_period, m.hp);
            chk("mon_run",   running,     m.hp != '0);
            chk("mon_done",  done,        m.done);
            chk("mon_ready", set_ready,   (m.busy == 8'd0) && !m.pv);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic request(input logic [FREQ_W-1:0] f);
        int i;
        i = 0;
        while (!set_ready && i < 500) begin
            @(negedge clk);
            i++;
        end
        chk("req_ready", set_ready, 1'b1);
        set_valid = 1'b1;
        freq_set  = f;
        @(negedge clk);
        set_valid = 1'b0;
        freq_set  = FREQ_W'($urandom);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic level_len(output int n);
        logic lv;
        lv = wave_out;
        n  = 0;
        while (wave_out == lv && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wave"},  wave_out,    1'b0);
        chk({tag, "_run"},   running,     1'b0);
        chk({tag, "_hp"},    half_period, '0);
        chk({tag, "_done"},  done,        1'b0);
        chk({tag, "_ready"}, set_ready,   1'b1);
    endtask

    task automatic async_reset(input string tag);
        #3 rstn = 1'b0;
        #1 check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k, n, lows, sel;
        logic [FREQ_W-1:0] f;

        rstn      = 1'b0;
        set_valid = 1'b0;
        freq_set  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rstn   = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // 1 MHz from stopped: fixed latency, 12-cycle levels
        request(FREQ_W'(1_000_000));
        lows = 0;
        k    = 0;
        while (!done && k < 300) begin
            if (!set_ready) lows++;
            @(negedge clk);
            k++;
        end
        chk("t1_latency",   k,           CNT_W + 1);
        chk("t1_ready_low", lows,        CNT_W + 1);
        chk("t1_hp",        half_period, 12);
        chk("t1_run",       running,     1'b1);
        chk("t1_wave",      wave_out,    1'b1);
        level_len(n);
        chk("t1_high_len",  n, 12);
        level_len(n);
        chk("t1_low_len",   n, 12);

        // 500 kHz while running: adopted at a toggle, next level 25 cycles
        request(FREQ_W'(500_000));
        chk("t2_hp_hold", half_period, 12);
        wait_done(k);
        chk("t2_hp", half_period, 25);
        level_len(n);
        chk("t2_new_len", n, 25);

        // Back to 1 MHz, then stop, then stop again while stopped
        request(FREQ_W'(1_000_000));
        wait_done(k);
        chk("t4_hp12", half_period, 12);
        request('0);
        wait_done(k);
        chk("t4_stop_wave", wave_out,    1'b0);
        chk("t4_stop_run",  running,     1'b0);
        chk("t4_stop_hp",   half_period, '0);
        request('0);
        wait_done(k);
        chk("t4_zero_latency", k,           CNT_W + 1);
        chk("t4_zero_hp",      half_period, '0);
        chk("t4_zero_wave",    wave_out,    1'b0);

        // Held set_valid with changing data while running
        request(FREQ_W'(1_000_000));
        wait_done(k);
        for (int i = 0; i < 40; i++) begin
            set_valid = 1'b1;
            freq_set  = FREQ_W'($urandom_range(200_000, 3_000_000));
            @(negedge clk);
        end
        set_valid = 1'b0;

        // Random mix of ordinary rates, stops and clamped rates
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      f = '0;
            else if (sel == 1) f = FREQ_W'($urandom_range(12_500_001, 30_000_000));
            else               f = FREQ_W'($urandom_range(200_000, 3_000_000));
            request(f);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        // Reset in the middle of a divide
        k = 0;
        while (!set_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        request(FREQ_W'(700_000));
        repeat (10) @(negedge clk);
        async_reset("t6_div");
        chk("t6_div_rel_ready", set_ready, 1'b1);
        repeat (50) @(negedge clk);
        chk("t6_div_idle_wave", wave_out, 1'b0);
        chk("t6_div_idle_run",  running,  1'b0);

        // Clamp to half_period 1, then very slow rate
        request(FREQ_W'(20_000_000));
        wait_done(k);
        chk("t3_clamp_hp", half_period, 1);
        repeat (6) @(negedge clk);
        request(FREQ_W'(12_500_000));
        wait_done(k);
        chk("t3_max_hp", half_period, 1);
        request(FREQ_W'(3));
        wait_done(k);
        chk("t3_slow_hp", half_period, 4_166_666);

        // Reset with an update pending
        request(FREQ_W'(1_000_000));
        repeat (40) @(negedge clk);
        chk("t6_pend_ready", set_ready, 1'b0);
        async_reset("t6_pend");
        chk("t6_pend_rel_ready", set_ready, 1'b1);
        chk("t6_pend_rel_wave",  wave_out,  1'b0);
        repeat (60) @(negedge clk);
        chk("t6_pend_idle_wave", wave_out,    1'b0);
        chk("t6_pend_idle_hp",   half_period, '0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
